// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell sequenced LSB-first over WIDTH cycles,
// with the carry held in a register between bits and the sum gathered in parallel.
module full_adder (
    input  logic in_1,
    input  logic in_2,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = in_1 ^ in_2 ^ cin;
    assign carry = (in_1 & in_2) | (in_1 & cin) | (in_2 & cin);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
    logic             carry_r;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_carry;
    logic             last_bit;

    full_adder u_fa (
        .in_1  (a_sr[0]),
        .in_2  (b_sr[0]),
        .cin   (carry_r),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
    if (WIDTH == 1) begin : g_s1
        assign s_next = fa_sum;
    end else begin : g_sn
        assign s_next = {fa_sum, s_sr[WIDTH-1:1]};
    end

    assign last_bit = (cnt == LAST);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr    <= a_in;
                        b_sr    <= b_in;
                        carry_r <= cin;
                        cnt     <= '0;
                    end
                end
                S_SHIFT: begin
                    s_sr    <= s_next;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry_r <= fa_carry;
                    cnt     <= cnt + 1'b1;
                    if (last_bit) begin
                        sum_out <= s_next;
                        cout    <= fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
